sonic_gearbox_tx_xg: RTL and testbench

SONIC_GEARBOX_TX_XG -- requirements
Module: sonic_gearbox_tx_xg

---
 rtl/sonic_xg_pkg.sv | 17 +
 rtl/sonic_gearbox_tx_xg_if.sv | 25 ++
 rtl/sonic_gearbox_tx_xg.sv | 105 ++++++++++
 tb/tb_sonic_gearbox_tx_xg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_xg_pkg.sv
// Shared 10G 64b/66b constants, used by the transmit gearbox and the receive blocksync.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: block/word widths, sync header codes, gearbox buffer sizing.
package sonic_xg_pkg;

  localparam int BLOCK_W = 66;  // encoded block, sync header in [1:0]
  localparam int WORD_W  = 64;  // transport word

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Worst case before an emit is fill=63 plus one block = 129 bits, so 130 covers it.
  localparam int BUF_W  = 2 * BLOCK_W - 2;
  localparam int FILL_W = 7;    // fill count 0..65

endpackage

// File: rtl/sonic_gearbox_tx_xg_if.sv
// Block-in / word-out bus of the 66b->64b transmit gearbox.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid; the word side has no backpressure.
// Signals: in_valid/in_data/in_ready (66-bit blocks in), out_valid/out_data (64-bit words out).
// Modports: master = block source / word sink, slave = gearbox.
interface sonic_gearbox_tx_xg_if;
  import sonic_xg_pkg::*;

  logic               in_valid;
  logic [BLOCK_W-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [WORD_W-1:0]  out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sonic_gearbox_tx_xg.sv
// 66b->64b transmit gearbox: packs 66-bit encoded blocks into a 64-bit word stream, bit 0 first.
// Latency: 1 cycle (block bit 0 accepted at edge N is in out_data after edge N when buffer empty).
// Backpressure: in_ready = fill < 64 from registered fill; a word is emitted whenever 64 bits exist.
// Ports: clk, reset (async, active-high), bus (slave modport: in_valid/in_data/in_ready,
//        out_valid/out_data), underflow (pulse when no word could be emitted),
//        underflow_cnt (saturating), tx_slip (only with SONIC_GEARBOX_TX_SLIP_EN: drop oldest bit).
// Build option: define SONIC_GEARBOX_TX_SLIP_EN to add the tx_slip port and bit-slip logic.
module sonic_gearbox_tx_xg
  import sonic_xg_pkg::*;
#(
  parameter int UFLOW_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef SONIC_GEARBOX_TX_SLIP_EN
  input  logic                   tx_slip,
`endif
  sonic_gearbox_tx_xg_if.slave   bus,
  output logic                   underflow,
  output logic [UFLOW_CNT_W-1:0] underflow_cnt
);

  // Buffer holds valid bits in [fill-1:0], oldest at bit 0; bits above fill are always zero,
  // which lets a new block be merged in with a plain OR.
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [WORD_W-1:0]      out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   underflow_q, underflow_d;
  logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

  // Intermediate buffer views: after optional slip, after optional append.
  logic [BUF_W-1:0]       buf_s, buf_t;
  logic [FILL_W-1:0]      fill_s;
  logic [FILL_W:0]        total;
  logic                   in_ready;
  logic                   accept;

  assign in_ready = (fill_q < FILL_W'(WORD_W));

  always_comb begin
    buf_s  = buf_q;
    fill_s = fill_q;
`ifdef SONIC_GEARBOX_TX_SLIP_EN
    // Slip drops the oldest bit before this cycle's append; ignored on an empty buffer.
    if (tx_slip && (fill_q != '0)) begin
      buf_s  = buf_q >> 1;
      fill_s = fill_q - FILL_W'(1);
    end
`endif

    accept = bus.in_valid && in_ready;
    buf_t  = buf_s;
    total  = {1'b0, fill_s};
    if (accept) begin
      buf_t = buf_s | (BUF_W'(bus.in_data) << fill_s);
      total = {1'b0, fill_s} + (FILL_W+1)'(BLOCK_W);
    end

    buf_d       = buf_t;
    fill_d      = total[FILL_W-1:0];
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underflow_d = 1'b0;
    uflow_cnt_d = uflow_cnt_q;

    if (total >= (FILL_W+1)'(WORD_W)) begin
      out_data_d  = buf_t[WORD_W-1:0];
      out_valid_d = 1'b1;
      buf_d       = buf_t >> WORD_W;
      fill_d      = FILL_W'(total - (FILL_W+1)'(WORD_W));
    end else begin
      // Not enough bits for a word: out_data keeps its last value.
      underflow_d = 1'b1;
      if (uflow_cnt_q != '1) begin
        uflow_cnt_d = uflow_cnt_q + UFLOW_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      uflow_cnt_q <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign underflow      = underflow_q;
  assign underflow_cnt  = uflow_cnt_q;

endmodule

// File: tb/tb_sonic_gearbox_tx_xg.sv
// Self-checking bench for sonic_gearbox_tx_xg against a bit-queue reference model.
// Each cycle the model appends accepted blocks bit by bit and pops 64 bits per word.
module tb_sonic_gearbox_tx_xg;

  logic        clk = 1'b0;
  logic        reset;
  logic        slip;
  logic        uf;
  logic [15:0] ucnt;

  always #5 clk = ~clk;

  sonic_gearbox_tx_xg_if bus ();

  sonic_gearbox_tx_xg #(.UFLOW_CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef SONIC_GEARBOX_TX_SLIP_EN
    .tx_slip       (slip),
`endif
    .bus           (bus),
    .underflow     (uf),
    .underflow_cnt (ucnt)
  );

  // Reference model state.
  bit          mq[$];      // buffered bits, oldest first
  bit          obs_q[$];   // bits seen on out_data while out_valid
  logic [63:0] exp_data;
  logic        exp_valid;
  logic        exp_uf;
  logic [15:0] exp_cnt;
  logic        exp_rdy;
  logic        obs_rdy;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    mq.delete();
    obs_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_uf    = 1'b0;
    exp_cnt   = '0;
  endtask

  // One clock cycle: drive inputs, sample in_ready, clock, advance the model.
  task automatic cycle(input logic v, input logic [65:0] d, input logic s);
    bus.in_valid = v;
    bus.in_data  = d;
    slip         = s;
    #1;
    obs_rdy = bus.in_ready;
    exp_rdy = (mq.size() < 64);
    @(posedge clk);
    #1;
`ifdef SONIC_GEARBOX_TX_SLIP_EN
    if (s && mq.size() > 0) void'(mq.pop_front());
`endif
    if (v && exp_rdy)
      for (int i = 0; i < 66; i++) mq.push_back(d[i]);
    if (mq.size() >= 64) begin
      for (int i = 0; i < 64; i++) exp_data[i] = mq.pop_front();
      exp_valid = 1'b1;
      exp_uf    = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_uf    = 1'b1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    if (bus.out_valid === 1'b1)
      for (int i = 0; i < 64; i++) obs_q.push_back(bus.out_data[i]);
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    slip         = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [65:0] rnd_blk();
    return {$urandom(), $urandom(), 2'($urandom())};
  endfunction

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    slip         = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", uf); end
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL reset_underflow_cnt got %h exp 0", ucnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // 66 cycles of continuous in_valid with indexed data-header blocks.
  task automatic test_continuous();
    int          acc_n, word_n, low_n, low1, low2;
    logic [65:0] d;
    logic [65:0] blk;
    acc_n = 0; word_n = 0; low_n = 0; low1 = 0; low2 = 0;
    apply_reset();
    for (int c = 1; c <= 66; c++) begin
      d = {64'(acc_n), 2'b01};
      cycle(1'b1, d, 1'b0);
      if (obs_rdy === 1'b1) acc_n++;
      else begin
        low_n++;
        if (low_n == 1) low1 = c; else if (low_n == 2) low2 = c;
      end
      if (bus.out_valid === 1'b1) word_n++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL cont_ready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
      checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL cont_valid c=%0d got %b exp %b", c, bus.out_valid, exp_valid); end
      checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL cont_data c=%0d got %h exp %h", c, bus.out_data, exp_data); end
    end
    checks++; if (acc_n != 64) begin errors++; $display("FAIL cont_accepts got %0d exp 64", acc_n); end
    checks++; if (word_n != 66) begin errors++; $display("FAIL cont_words got %0d exp 66", word_n); end
    checks++; if (low_n != 2 || low1 != 33 || low2 != 66) begin
      errors++; $display("FAIL cont_ready_low got n=%0d at %0d,%0d exp n=2 at 33,66", low_n, low1, low2);
    end
    checks++; if (obs_q.size() != 66 * 64) begin errors++; $display("FAIL cont_stream_len got %0d exp %0d", obs_q.size(), 66 * 64); end
    else begin
      for (int k = 0; k < 64; k++) begin
        for (int i = 0; i < 66; i++) blk[i] = obs_q[66 * k + i];
        checks++; if (blk !== {64'(k), 2'b01}) begin errors++; $display("FAIL cont_block k=%0d got %h exp %h", k, blk, {64'(k), 2'b01}); end
      end
    end
    // Empty buffer at the end: the next block must come out starting at bit 0.
    d = rnd_blk();
    cycle(1'b1, d, 1'b0);
    checks++; if (bus.out_data !== d[63:0] || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL cont_fill0 got %b/%h exp 1/%h", bus.out_valid, bus.out_data, d[63:0]);
    end
  endtask

  // Three idle cycles at fill=10, then random traffic.
  task automatic test_underflow();
    apply_reset();
    for (int c = 0; c < 5; c++) cycle(1'b1, rnd_blk(), 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, rnd_blk(), 1'b0);
      checks++; if (bus.out_valid !== 1'b0 || uf !== 1'b1) begin
        errors++; $display("FAIL uflow_idle c=%0d got valid=%b uf=%b exp valid=0 uf=1", c, bus.out_valid, uf);
      end
    end
    checks++; if (ucnt !== 16'd3) begin errors++; $display("FAIL uflow_cnt3 got %0d exp 3", ucnt); end
    for (int c = 0; c < 60; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), rnd_blk(), 1'b0);
      checks++; if (bus.out_valid !== exp_valid || bus.out_data !== exp_data || uf !== exp_uf || ucnt !== exp_cnt) begin
        errors++; $display("FAIL uflow_resume c=%0d got %b/%h/%b/%0d exp %b/%h/%b/%0d",
                           c, bus.out_valid, bus.out_data, uf, ucnt, exp_valid, exp_data, exp_uf, exp_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int c = 0; c < 65534; c++) cycle(1'b0, '0, 1'b0);
    checks++; if (ucnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h exp fffe", ucnt); end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, '0, 1'b0);
      checks++; if (ucnt !== 16'hFFFF || uf !== 1'b1) begin
        errors++; $display("FAIL sat_hold c=%0d got cnt=%h uf=%b exp cnt=ffff uf=1", c, ucnt, uf);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [65:0] d;
    apply_reset();
    cycle(1'b0, '0, 1'b0);  // one underflow so the counter is non-zero
    for (int c = 0; c < 20; c++) cycle(1'b1, rnd_blk(), 1'b0);  // fill = 40
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0) begin
      errors++; $display("FAIL rmid_out got %b/%h exp 0/0", bus.out_valid, bus.out_data);
    end
    checks++; if (ucnt !== 16'd0 || uf !== 1'b0) begin errors++; $display("FAIL rmid_uflow got %0d/%b exp 0/0", ucnt, uf); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    d = rnd_blk();
    d[1:0] = 2'b10;
    cycle(1'b1, d, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d[63:0]) begin
      errors++; $display("FAIL rmid_first got %b/%h exp 1/%h", bus.out_valid, bus.out_data, d[63:0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      cycle(1'($urandom_range(0, 4) != 0), rnd_blk(), 1'b0);
      checks++; if (obs_rdy !== exp_rdy || bus.out_valid !== exp_valid || bus.out_data !== exp_data ||
                    uf !== exp_uf || ucnt !== exp_cnt) begin
        errors++; $display("FAIL rand c=%0d got %b/%b/%h/%b/%0d exp %b/%b/%h/%b/%0d", c, obs_rdy, bus.out_valid,
                           bus.out_data, uf, ucnt, exp_rdy, exp_valid, exp_data, exp_uf, exp_cnt);
      end
    end
  endtask

`ifdef SONIC_GEARBOX_TX_SLIP_EN
  task automatic test_slip();
    int          acc_n;
    logic [65:0] d;
    acc_n = 0;
    apply_reset();
    for (int c = 0; c < 51; c++) begin
      d = {64'(acc_n), 2'b01};
      cycle(1'b1, d, 1'(c == 10));  // slip lands at fill = 20
      if (obs_rdy === 1'b1) acc_n++;
      checks++; if (bus.out_valid !== exp_valid || bus.out_data !== exp_data) begin
        errors++; $display("FAIL slip_stream c=%0d got %b/%h exp %b/%h", c, bus.out_valid, bus.out_data, exp_valid, exp_data);
      end
    end
    for (int k = 10; 66 * k + 1 < obs_q.size(); k++) begin
      checks++; if (obs_q[66 * k - 1] !== 1'b1 || obs_q[66 * k] !== 1'b0) begin
        errors++; $display("FAIL slip_header k=%0d got %b%b exp 01", k, obs_q[66 * k], obs_q[66 * k - 1]);
      end
    end
    apply_reset();
    d = rnd_blk();
    cycle(1'b1, d, 1'b1);  // slip on empty buffer is ignored
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d[63:0]) begin
      errors++; $display("FAIL slip_fill0 got %b/%h exp 1/%h", bus.out_valid, bus.out_data, d[63:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_underflow();
    test_reset_mid();
    test_random();
`ifdef SONIC_GEARBOX_TX_SLIP_EN
    test_slip();
`endif
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
